// File: rtl/uart_wb_pkg.sv
// Shared command/response codes, FSM state type and sizing helper for the
// UART-to-Wishbone debug bridge.
package uart_wb_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    // Bus-timeout counter width: never below 8 bits, wider when the limit needs it.
    function automatic int unsigned timeout_width(input int unsigned cycles);
        return (cycles > 32'd255) ? $clog2(cycles + 32'd1) : 32'd8;
    endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Wishbone classic-cycle bus bundle; signal names are seen from the initiator side.
interface uart_wb_master_if;

    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;

    modport master (
        output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
        output dat_i, ack_i
    );

endinterface

// File: rtl/uart_wb_master.sv
// UART byte stream -> Wishbone initiator: 'W'+addr+data writes, 'R'+addr reads.
// Optional bus timeout with 'E' reply is compiled in by defining UART_WB_TIMEOUT_EN.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_byte_o,
    output logic       tx_valid_o,
    input  logic       tx_busy_i,
    output logic       busy_o,
    uart_wb_master_if.master wb
);

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_is_wr;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_we;
    logic        r_cyc;
    logic        r_busy;
    logic [31:0] r_resp;
    logic [2:0]  r_resp_cnt;
    logic [7:0]  r_tx_byte;
    logic        r_tx_valid;

`ifdef UART_WB_TIMEOUT_EN
    localparam int unsigned   TO_W    = timeout_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
`else
    wire w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // NOTE: non-blocking assignments throughout; the strobe default at the top
    // of the clocked branch is overridden by any later assignment in the same edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 2'd0;
            r_is_wr    <= 1'b0;
            r_adr      <= 32'h0;
            r_dat      <= 32'h0;
            r_we       <= 1'b0;
            r_cyc      <= 1'b0;
            r_busy     <= 1'b0;
            r_resp     <= 32'h0;
            r_resp_cnt <= 3'd0;
            r_tx_byte  <= 8'h0;
            r_tx_valid <= 1'b0;
`ifdef UART_WB_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            r_tx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid_i && (rx_byte_i == CMD_WR || rx_byte_i == CMD_RD)) begin
                        r_is_wr <= (rx_byte_i == CMD_WR);
                        r_cnt   <= 2'd0;
                        r_state <= ST_ADDR;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid_i) begin
                        r_adr <= {r_adr[23:0], rx_byte_i};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= r_is_wr ? ST_DATA : ST_BUS;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid_i) begin
                        r_dat <= {r_dat[23:0], rx_byte_i};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    // First BUS cycle only raises the strobe; ack is honoured once cyc is out.
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                        r_we  <= r_is_wr;
                    end else if (wb.ack_i) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= ST_RESP;
                        if (r_is_wr) begin
                            r_resp     <= {RSP_OK, 24'h0};
                            r_resp_cnt <= 3'd1;
                        end else begin
                            r_resp     <= wb.dat_i;
                            r_resp_cnt <= 3'd4;
                        end
                    end
`ifdef UART_WB_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_cyc      <= 1'b0;
                        r_we       <= 1'b0;
                        r_state    <= ST_RESP;
                        r_resp     <= {RSP_ERR, 24'h0};
                        r_resp_cnt <= 3'd1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (!tx_busy_i && !r_tx_valid) begin
                        r_tx_byte  <= r_resp[31:24];
                        r_tx_valid <= 1'b1;
                        r_resp     <= {r_resp[23:0], 8'h0};
                        r_resp_cnt <= r_resp_cnt - 3'd1;
                        if (r_resp_cnt == 3'd1) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
`ifdef UART_WB_TIMEOUT_EN
            if (r_state != ST_BUS) begin
                r_to_cnt <= '0;
            end
`endif
        end
    end

    assign tx_byte_o  = r_tx_byte;
    assign tx_valid_o = r_tx_valid;
    assign busy_o     = r_busy;

    assign wb.adr_o = r_adr;
    assign wb.dat_o = r_dat;
    assign wb.we_o  = r_we;
    assign wb.sel_o = 4'hF;
    assign wb.cyc_o = r_cyc;
    assign wb.stb_o = r_cyc;

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: vector table, hand-written corner
// sequences, and randomized frames against a frame-level reference model.
module tb_uart_wb_master;
    import uart_wb_pkg::*;

    localparam int unsigned TO_CYC = 16;

    typedef logic [7:0] byte_q_t [$];

    typedef struct {
        logic [95:0] bytes;      // frame bytes, right-aligned, first byte most significant
        int          n_bytes;
        int          ack_delay;
        logic [31:0] rd_data;
        int          exp_nbus;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic        exp_we;
        logic [31:0] exp_tx;     // reply bytes, right-aligned
        int          exp_ntx;
    } vec_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } bus_t;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] rx_byte_i;
    logic       rx_valid_i;
    logic [7:0] tx_byte_o;
    logic       tx_valid_o;
    logic       tx_busy_i;
    logic       busy_o;

    int n_cmp = 0;
    int n_err = 0;

    bus_t       bus_q[$];
    logic [7:0] tx_q[$];

    int          ack_delay = 0;
    logic        no_ack    = 1'b0;
    logic [31:0] rd_data   = 32'h0;
    int          slv_wait  = 0;
    int          busy_len  = 2;
    int          busy_cnt  = 0;
    logic        tx_pending = 1'b0;
    logic        prev_valid = 1'b0;

    always #5 clk_i = ~clk_i;

    uart_wb_master_if wb_if();

    uart_wb_master #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_byte_i  (rx_byte_i),
        .rx_valid_i (rx_valid_i),
        .tx_byte_o  (tx_byte_o),
        .tx_valid_o (tx_valid_o),
        .tx_busy_i  (tx_busy_i),
        .busy_o     (busy_o),
        .wb         (wb_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Wishbone slave: acks after ack_delay cycles of cyc, logs every acknowledged access.
    always @(negedge clk_i) begin
        wb_if.dat_i = rd_data;
        if (wb_if.cyc_o && !wb_if.ack_i && !no_ack && !rst_i) begin
            if (slv_wait >= ack_delay) begin
                wb_if.ack_i = 1'b1;
                bus_q.push_back('{adr: wb_if.adr_o, dat: wb_if.dat_o, we: wb_if.we_o});
                check("bus_stb", 32'(wb_if.stb_o), 32'd1);
                check("bus_sel", 32'(wb_if.sel_o), 32'hF);
                slv_wait = 0;
            end else begin
                slv_wait++;
            end
        end else begin
            wb_if.ack_i = 1'b0;
            if (!wb_if.cyc_o) slv_wait = 0;
        end
    end

    // UART transmitter: busy rises the cycle after a strobe and stays up busy_len cycles.
    always @(negedge clk_i) begin
        if (tx_pending) begin
            tx_busy_i  = 1'b1;
            busy_cnt   = busy_len;
            tx_pending = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy_i = 1'b0;
        end else begin
            tx_busy_i = 1'b0;
        end
        if (tx_valid_o) begin
            check("tx_strobe_width", 32'(prev_valid), 32'd0);
            tx_q.push_back(tx_byte_o);
            tx_pending = 1'b1;
        end
        prev_valid = tx_valid_o;
    end

    // Frame-level reference: find the command, fold the fields arithmetically, pick the reply.
    function automatic void model(input byte_q_t q, input logic [31:0] rd,
                                  output int nbus, output logic [31:0] adr,
                                  output logic [31:0] dat, output logic we,
                                  output logic [31:0] tx, output int ntx);
        int i;
        longint unsigned a;
        longint unsigned d;
        i = 0; a = 0; d = 0;
        nbus = 0; adr = 0; dat = 0; we = 0; tx = 0; ntx = 0;
        while (i < q.size() && q[i] != CMD_WR && q[i] != CMD_RD) i++;
        if (i + 5 > q.size()) return;
        we = (q[i] == CMD_WR);
        i++;
        for (int k = 0; k < 4; k++) a = (a * 256 + longint'(q[i+k])) % 64'h1_0000_0000;
        i += 4;
        if (we) begin
            for (int k = 0; k < 4; k++) d = (d * 256 + longint'(q[i+k])) % 64'h1_0000_0000;
        end
        nbus = 1;
        adr  = a[31:0];
        dat  = d[31:0];
        if (we) begin
            tx  = 32'(RSP_OK);
            ntx = 1;
        end else begin
            tx  = rd;
            ntx = 4;
        end
    endfunction

    task automatic send_bytes(input byte_q_t q, input int gap);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk_i);
            rx_byte_i  = q[i];
            rx_valid_i = 1'b1;
            repeat (gap) begin
                @(negedge clk_i);
                rx_valid_i = 1'b0;
            end
        end
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o || tx_busy_i) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 2000) bound_fail({name, " idle"});
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_frame(input string name, input int nbus, input logic [31:0] adr,
                               input logic [31:0] dat, input logic we,
                               input logic [31:0] tx, input int ntx);
        int m;
        check({name, " bus_count"}, 32'(bus_q.size()), 32'(nbus));
        if (bus_q.size() > 0 && nbus > 0) begin
            check({name, " adr"}, bus_q[0].adr, adr);
            check({name, " we"}, 32'(bus_q[0].we), 32'(we));
            if (we) check({name, " dat"}, bus_q[0].dat, dat);
        end
        check({name, " tx_count"}, 32'(tx_q.size()), 32'(ntx));
        m = (tx_q.size() < ntx) ? tx_q.size() : ntx;
        for (int i = 0; i < m; i++) begin
            check({name, " tx_byte"}, 32'(tx_q[i]), 32'(tx[8*(ntx-1-i) +: 8]));
        end
        bus_q.delete();
        tx_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[4];
        byte_q_t     q;
        int          nbus, ntx, n, cyc_len;
        logic [31:0] e_adr, e_dat, e_tx, r_adr, r_dat;
        logic        e_we, is_wr;
        logic [7:0]  b;

        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_byte_i  = 8'h0;

        vecs[0] = '{bytes: 96'h57_00000800_00000041, n_bytes: 9, ack_delay: 2,
                    rd_data: 32'h0, exp_nbus: 1, exp_adr: 32'h800, exp_dat: 32'h41,
                    exp_we: 1'b1, exp_tx: 32'h4B, exp_ntx: 1};
        vecs[1] = '{bytes: 96'h52_00000800, n_bytes: 5, ack_delay: 1,
                    rd_data: 32'hDEADBEEF, exp_nbus: 1, exp_adr: 32'h800, exp_dat: 32'h0,
                    exp_we: 1'b0, exp_tx: 32'hDEADBEEF, exp_ntx: 4};
        vecs[2] = '{bytes: 96'h00_FF_41_52_12345678, n_bytes: 8, ack_delay: 0,
                    rd_data: 32'h0BADF00D, exp_nbus: 1, exp_adr: 32'h12345678, exp_dat: 32'h0,
                    exp_we: 1'b0, exp_tx: 32'h0BADF00D, exp_ntx: 4};
        vecs[3] = '{bytes: 96'h57_FFFFFFFC_A55A00FF, n_bytes: 9, ack_delay: 0,
                    rd_data: 32'h0, exp_nbus: 1, exp_adr: 32'hFFFFFFFC, exp_dat: 32'hA55A00FF,
                    exp_we: 1'b1, exp_tx: 32'h4B, exp_ntx: 1};

        repeat (3) @(negedge clk_i);
        check("rst tx_byte", 32'(tx_byte_o), 32'h0);
        check("rst tx_valid", 32'(tx_valid_o), 32'h0);
        check("rst adr", wb_if.adr_o, 32'h0);
        check("rst dat", wb_if.dat_o, 32'h0);
        check("rst we", 32'(wb_if.we_o), 32'h0);
        check("rst sel", 32'(wb_if.sel_o), 32'hF);
        check("rst cyc", 32'(wb_if.cyc_o), 32'h0);
        check("rst stb", 32'(wb_if.stb_o), 32'h0);
        check("rst busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;

        for (int i = 0; i < 4; i++) begin
            ack_delay = vecs[i].ack_delay;
            rd_data   = vecs[i].rd_data;
            q = {};
            for (int k = 0; k < vecs[i].n_bytes; k++)
                q.push_back(vecs[i].bytes[8*(vecs[i].n_bytes-1-k) +: 8]);
            send_bytes(q, 1);
            wait_idle($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i), vecs[i].exp_nbus, vecs[i].exp_adr,
                        vecs[i].exp_dat, vecs[i].exp_we, vecs[i].exp_tx, vecs[i].exp_ntx);
        end

        // Cycle-exact bus start/end and first reply slot, back-to-back frame bytes.
        ack_delay = 0;
        send_bytes('{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78}, 0);
        check("timing cyc_gap", 32'(wb_if.cyc_o), 32'd0);
        check("timing busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        check("timing cyc_up", 32'(wb_if.cyc_o), 32'd1);
        check("timing stb_up", 32'(wb_if.stb_o), 32'd1);
        check("timing we", 32'(wb_if.we_o), 32'd1);
        check("timing adr", wb_if.adr_o, 32'h10);
        check("timing dat", wb_if.dat_o, 32'h12345678);
        @(negedge clk_i);
        check("timing cyc_down", 32'(wb_if.cyc_o), 32'd0);
        check("timing no_early_tx", 32'(tx_valid_o), 32'd0);
        @(negedge clk_i);
        check("timing first_tx", 32'(tx_valid_o), 32'd1);
        check("timing first_byte", 32'(tx_byte_o), 32'h4B);
        wait_idle("timing");
        check_frame("timing", 1, 32'h10, 32'h12345678, 1'b1, 32'h4B, 1);

        // Bytes arriving during BUS and RESP must be ignored.
        ack_delay = 6;
        busy_len  = 3;
        rd_data   = 32'hCAFE0123;
        send_bytes('{8'h52, 8'h00, 8'h00, 8'h00, 8'h20}, 0);
        send_bytes('{8'h57, 8'h52, 8'h00, 8'h57}, 0);
        n = 0;
        while (tx_q.size() < 1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) bound_fail("inject resp_start");
        check("inject busy_in_resp", 32'(busy_o), 32'd1);
        send_bytes('{8'h52, 8'h57, 8'h00}, 0);
        wait_idle("inject");
        check_frame("inject", 1, 32'h20, 32'h0, 1'b0, 32'hCAFE0123, 4);
        ack_delay = 1;
        send_bytes('{8'h57, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00, 8'h99}, 1);
        wait_idle("after_inject");
        check_frame("after_inject", 1, 32'h24, 32'h99, 1'b1, 32'h4B, 1);

        // Asynchronous reset while the bus cycle is open.
        no_ack = 1'b1;
        send_bytes('{8'h57, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h01}, 0);
        n = 0;
        while (!wb_if.cyc_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 10) bound_fail("reset cyc_rise");
        #2 rst_i = 1'b1;
        #1;
        check("reset cyc_async", 32'(wb_if.cyc_o), 32'd0);
        check("reset stb_async", 32'(wb_if.stb_o), 32'd0);
        check("reset busy_async", 32'(busy_o), 32'd0);
        check("reset adr_async", wb_if.adr_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_i  = 1'b0;
        no_ack = 1'b0;
        repeat (10) @(negedge clk_i);
        check("reset no_tx", 32'(tx_q.size()), 32'd0);
        check("reset no_ack_txn", 32'(bus_q.size()), 32'd0);
        bus_q.delete();
        tx_q.delete();
        rd_data = 32'h01020304;
        send_bytes('{8'h52, 8'h00, 8'h00, 8'h00, 8'h34}, 1);
        wait_idle("post_reset");
        check_frame("post_reset", 1, 32'h34, 32'h0, 1'b0, 32'h01020304, 4);

`ifdef UART_WB_TIMEOUT_EN
        no_ack = 1'b1;
        send_bytes('{8'h52, 8'h00, 8'h00, 8'h00, 8'h40}, 0);
        cyc_len = 0;
        n = 0;
        while ((cyc_len == 0 || wb_if.cyc_o) && n < 100) begin
            if (wb_if.cyc_o) cyc_len++;
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) bound_fail("timeout cyc_fall");
        check("timeout cyc_len", 32'(cyc_len), 32'(TO_CYC));
        wait_idle("timeout");
        check_frame("timeout", 0, 32'h0, 32'h0, 1'b0, 32'(RSP_ERR), 1);
        no_ack = 1'b0;
`else
        cyc_len = 0;
`endif

        for (int it = 0; it < 40; it++) begin
            q = {};
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == CMD_WR || b == CMD_RD) b = 8'h00;
                q.push_back(b);
            end
            is_wr = 1'($urandom_range(0, 1));
            r_adr = $urandom;
            r_dat = $urandom;
            q.push_back(is_wr ? CMD_WR : CMD_RD);
            for (int k = 0; k < 4; k++) q.push_back(8'((r_adr >> (24 - 8*k)) % 256));
            if (is_wr) begin
                for (int k = 0; k < 4; k++) q.push_back(8'((r_dat >> (24 - 8*k)) % 256));
            end
            rd_data   = $urandom;
            ack_delay = int'($urandom_range(0, 4));
            busy_len  = int'($urandom_range(1, 3));
            model(q, rd_data, nbus, e_adr, e_dat, e_we, e_tx, ntx);
            send_bytes(q, int'($urandom_range(0, 2)));
            wait_idle($sformatf("rand%0d", it));
            check_frame($sformatf("rand%0d", it), nbus, e_adr, e_dat, e_we, e_tx, ntx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
# uart_wb_master

UART-to-Wishbone debug bridge: consumes a byte stream from a UART receiver, decodes simple read/write commands, and drives a single Wishbone classic-cycle initiator port. It is the bus-master counterpart of the UART-backed Wishbone I/O slave. A host PC can use it to peek and poke any Wishbone slave, including the UART I/O controller, without CPU involvement.

## Interface
- TIMEOUT_CYCLES, 255: max cycles waiting for ack_i before abort (only with timeout compiled in)
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- rx_byte_i  input  8  received UART byte
- rx_valid_i  input  1  one-cycle strobe, rx_byte_i valid
- tx_byte_o  output  8  response byte to UART transmitter
- tx_valid_o  output  1  one-cycle strobe, tx_byte_o valid
- tx_busy_i  input  1  transmitter busy; must rise the cycle after accepting tx_valid_o
- adr_o  output  32  Wishbone byte address
- dat_o  output  32  Wishbone write data
- dat_i  input  32  Wishbone read data
- we_o  output  1  write enable
- sel_o  output  4  byte selects, constant 4'hF
- cyc_o  output  1  bus cycle
- stb_o  output  1  strobe, always equal to cyc_o
- ack_i  input  1  slave acknowledge
- busy_o  output  1  high whenever state is not IDLE

## Operation
- Command frames, multi-byte fields MSB first:
  - Write: 0x57 ('W'), 4 address bytes, 4 data bytes -> Wishbone write; reply 0x4B ('K').
  - Read: 0x52 ('R'), 4 address bytes -> Wishbone read; reply 4 data bytes, MSB first.
  - Any other byte in IDLE is dropped silently.
- States: IDLE -> ADDR (4 bytes) -> DATA (4 bytes, write only) -> BUS -> RESP -> IDLE.
- Byte position is tracked by a 2-bit counter. It wraps 3 -> 0 on the state change.
- Address and data are assembled by shift-left-by-8, new byte inserted into bits [7:0].
- BUS:
  - cyc_o=stb_o=1; we_o=1 for write.
  - Held until ack_i is sampled high.
  - On read, dat_i is latched into the response shift register on the ack edge.
- RESP: emits one byte per tx_valid_o pulse.
  - A pulse is issued only when tx_busy_i=0 and tx_valid_o was 0 in the previous cycle.
  - After the final byte is issued, return to IDLE.
- rx_valid_i during BUS or RESP: byte dropped, no state effect.
- A frame is never abandoned mid-receive; there is no inter-byte timeout.

## Timing
- Reset values:
  - tx_byte_o=0, tx_valid_o=0, adr_o=0, dat_o=0, we_o=0, sel_o=4'hF.
  - cyc_o=0, stb_o=0, busy_o=0, state=IDLE, counters=0.
- Reset mid-transaction: cyc_o/stb_o drop immediately (asynchronous). The partial frame is discarded and no reply is sent.
- Bus start: last frame byte strobed at edge N -> cyc_o/stb_o high after edge N+1.
- Bus end: ack_i high at edge M -> cyc_o/stb_o low after edge M (registered). Minimum bus cycle is 1 clock; ack_i high in the first cycle is legal.
- First response: tx_valid_o can pulse in the cycle after cyc_o falls.
- Subsequent response bytes: each needs a tx_busy_i high-then-low sequence.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- UART_WB_TIMEOUT_EN defined:
  - An 8-bit+ counter (sized to TIMEOUT_CYCLES) runs in BUS.
  - If TIMEOUT_CYCLES cycles elapse without ack_i, cyc_o/stb_o drop and the reply is the single byte 0x45 ('E'), for both read and write.
  - Counter clears on entry to BUS.
- UART_WB_TIMEOUT_EN undefined:
  - No counter; BUS waits indefinitely.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Shared package uart_wb_pkg holds:
  - Command codes CMD_WR=8'h57, CMD_RD=8'h52.
  - Response codes RSP_OK=8'h4B, RSP_ERR=8'h45.
  - State enum.
- Single module; no sub-module. The response serializer is a small in-module shift register plus a 3-bit byte count.

## Test plan
- Write: 57 00 00 08 00 00 00 00 41 -> one bus cycle, adr_o=0x00000800, dat_o=0x00000041, we_o=1; ack after 2 cycles; tx byte 0x4B.
- Read: 52 00 00 08 00 with dat_i=0xDEADBEEF on ack -> we_o=0; tx bytes DE AD BE EF in order, each gated by tx_busy_i.
- Garbage: bytes 00 FF 41, then a valid read frame -> garbage ignored; read completes normally.
- Bytes injected during BUS and RESP -> dropped; reply unchanged; next frame decoded correctly.
- Reset asserted while cyc_o=1 -> cyc_o/stb_o=0 without waiting for a clock edge; no tx pulse; state IDLE.
- With UART_WB_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack_i never asserted -> cyc_o low after 16 cycles; tx byte 0x45.
